stl_rot_unshift: RTL and testbench
==================================

Name: stl_rot_unshift

Overview:
- Pipelined inverse lane rotator: takes a lane vector that was rotated by the combinational lane rotator and undoes that rotation, restoring the original lane order.
- Used on the read/return side of lane-rotated datapaths, where rotated words must be re-aligned before consumption.
- Two register stages with valid/ready flow control, full throughput, and a user tag carried alongside the data.

Parameters:
- DIM_N, 16, number of lanes.
- DAT_W, 10, bits per lane.
- SHT_W, 4, width of the rotate amount.
- TAG_W, 4, width of the sideband tag carried with each word.
- MODE, 0, direction used by the forward rotator: 0 = it rotated left, so this block rotates right; 1 = it rotated right, so this block rotates left.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous and active-high.
- in_vld  in  1  input word valid.
- in_rdy  out  1  block can accept the input word.
- in_dat  in  DIM_N*DAT_W  rotated lane vector; lane j occupies bits [j*DAT_W +: DAT_W].
- in_shft  in  SHT_W  rotate amount the forward rotator applied.
- in_tag  in  TAG_W  sideband tag.
- out_vld  out  1  output word valid.
- out_rdy  in  1  downstream accepts the output word.
- out_dat  out  DIM_N*DAT_W  de-rotated lane vector.
- out_tag  out  TAG_W  tag of the output word.
- err  out  1  sticky: an in_shft >= DIM_N was accepted.
- err_clr  in  1  synchronous clear of err.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_vld && in_rdy.
  - Output transfer occurs when out_vld && out_rdy.
  - in_dat, in_shft and in_tag are sampled only on a transfer.
- Shift-amount reduction: amount k = in_shft mod DIM_N, computed in stage 1. If in_shft >= DIM_N on an accepted word, err is set on the next edge.
- De-rotation, with k the reduced amount:
  - MODE=0: out lane j = in lane (j+k) mod DIM_N.
  - MODE=1: out lane j = in lane (j-k) mod DIM_N.
  - k=0 passes data through unchanged.
- Stage split: LO_W = ceil(SHT_W/2).
  - Stage 1 register holds the data rotated by the low LO_W bits of k, plus the remaining high bits of k, the tag, and s1_vld.
  - Stage 2 applies the rotation by (high bits << LO_W) and registers data, tag and s2_vld.
  - The two partial rotations compose to exactly k.
- Flow control:
  - s2_load = !s2_vld || out_rdy.
  - s1_load = !s1_vld || s2_load.
  - in_rdy = s1_load (combinational from out_rdy; there is no combinational path from in_vld to in_rdy).
  - A stage that is not loaded holds its contents, so data and tag stay stable under backpressure.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_vld when unstalled.
  - Sustains 1 word/cycle with out_rdy held high.
  - Capacity is 2 words. With out_rdy low and both stages full, in_rdy = 0.
- Stage draining:
  - If s1_vld is high, s2 loads and in_vld is low, stage 1 becomes empty.
  - Simultaneous output and input transfer on a full pipe: both stages shift, no bubble, no loss.
- Word order is preserved; the tag always stays paired with its own data.
- err behaviour:
  - err_clr and a new error on the same cycle leave err = 1 (set wins).
  - err_clr alone clears err to 0.
- Reset:
  - Values: s1_vld = 0, s2_vld = 0, out_vld = 0, err = 0, out_dat = 0, out_tag = 0, in_rdy = 1 (after reset the pipe is empty, so the in_rdy equation gives 1).
  - Reset asserted mid-stream discards all in-flight words immediately; nothing stale appears after reset is released.
- The forward rotator composed with this block, using the same MODE and a shift below DIM_N, is the identity.

Test Plan:
- Identity, MODE=0, shft=3:
  - Stimulus: lane j holds (j-3) mod 16, tag=5, out_rdy=1.
  - Response: 2 cycles later out lane j = j, out_tag = 5, err = 0.
- MODE=1, shft=15:
  - Stimulus: lane j holds (j+15) mod 16.
  - Response: out lane j = j.
  - Also: shft=0 returns the input unchanged.
- Streaming:
  - Stimulus: 20 back-to-back words with shft cycling 0..15, tag = word index, out_rdy=1.
  - Response: 20 outputs on consecutive cycles, in order, each correct.
- Backpressure:
  - Stimulus: hold out_rdy=0 while sending 3 words.
  - Response: in_rdy drops after 2 accepted; out_dat stays stable.
  - Release: on out_rdy=1, all 3 words emerge in order with no loss or duplication.
- Overrange amount:
  - Config: DIM_N=12, SHT_W=4.
  - Stimulus: shft=14.
  - Response: rotation by 2; err=1 on the next cycle and it stays set.
  - Clear: err_clr clears it; err_clr together with a new shft=13 keeps err=1.
- Reset mid-operation:
  - Stimulus: assert rst with both stages full.
  - Response: out_vld=0 and err=0 immediately.
  - After release: in_rdy=1 and no stale output appears.

Source files
------------

// File: rtl/stl_rot_unshift.sv
// Two-stage inverse lane rotator: undoes the forward rotation by k = in_shft mod DIM_N, tag carried alongside.
// Latency 2 cycles, 1 word/cycle; each stage holds under backpressure, in_rdy depends on out_rdy only.
module stl_rot_unshift #(
  parameter int DIM_N = 16,
  parameter int DAT_W = 10,
  parameter int SHT_W = 4,
  parameter int TAG_W = 4,
  parameter int MODE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DIM_N*DAT_W-1:0] in_dat,
  input  logic [SHT_W-1:0]       in_shft,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [DIM_N*DAT_W-1:0] out_dat,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int W    = DIM_N * DAT_W;
  localparam int LO_W = (SHT_W + 1) / 2;
  localparam int HI_W = SHT_W - LO_W;
  localparam int NRED = (1 << SHT_W) / DIM_N;
  localparam logic [SHT_W:0]   DIM_L = (SHT_W + 1)'(DIM_N);
  localparam logic [SHT_W-1:0] DIM_S = SHT_W'(DIM_N);

  // MODE=0 undoes a left rotation (out lane j <- in lane j+amt), MODE=1 undoes a right one.
  function automatic logic [W-1:0] rot_lanes(input logic [W-1:0] d, input int amt);
    logic [W-1:0] r;
    int a;
    int src;
    r = '0;
    a = amt % DIM_N;
    for (int j = 0; j < DIM_N; j++) begin
      if (MODE == 0) src = (j + a) % DIM_N;
      else           src = (j + DIM_N - a) % DIM_N;
      r[j*DAT_W +: DAT_W] = d[src*DAT_W +: DAT_W];
    end
    return r;
  endfunction

  logic [SHT_W-1:0] k_red;
  logic             shft_ovr;
  logic             in_xfer;
  logic             s1_load;
  logic             s2_load;

  logic             s1_vld_q, s1_vld_d;
  logic [W-1:0]     s1_dat_q, s1_dat_d;
  logic [HI_W-1:0]  s1_hi_q,  s1_hi_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_vld_q, s2_vld_d;
  logic [W-1:0]     s2_dat_q, s2_dat_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             err_q,    err_d;

  // Repeated conditional subtraction keeps the reduction valid for non power-of-two DIM_N.
  always_comb begin
    k_red = in_shft;
    for (int i = 0; i < NRED; i++) begin
      if ({1'b0, k_red} >= DIM_L) k_red = k_red - DIM_S;
    end
    shft_ovr = ({1'b0, in_shft} >= DIM_L);
  end

  assign s2_load = !s2_vld_q || out_rdy;
  assign s1_load = !s1_vld_q || s2_load;
  assign in_rdy  = s1_load;
  assign in_xfer = in_vld && in_rdy;

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_dat_d = s1_dat_q;
    s1_hi_d  = s1_hi_q;
    s1_tag_d = s1_tag_q;
    s2_vld_d = s2_vld_q;
    s2_dat_d = s2_dat_q;
    s2_tag_d = s2_tag_q;
    err_d    = err_q;

    if (s1_load) s1_vld_d = in_vld;
    if (in_xfer) begin
      s1_dat_d = rot_lanes(in_dat, int'(k_red[LO_W-1:0]));
      s1_hi_d  = k_red[SHT_W-1:LO_W];
      s1_tag_d = in_tag;
    end

    if (s2_load) s2_vld_d = s1_vld_q;
    if (s2_load && s1_vld_q) begin
      s2_dat_d = rot_lanes(s1_dat_q, int'(s1_hi_q) << LO_W);
      s2_tag_d = s1_tag_q;
    end

    // A new overrange amount wins over a simultaneous clear.
    if (in_xfer && shft_ovr) err_d = 1'b1;
    else if (err_clr)        err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s1_hi_q  <= '0;
      s1_tag_q <= '0;
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      s2_tag_q <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      s1_hi_q  <= s1_hi_d;
      s1_tag_q <= s1_tag_d;
      s2_vld_q <= s2_vld_d;
      s2_dat_q <= s2_dat_d;
      s2_tag_q <= s2_tag_d;
      err_q    <= err_d;
    end
  end

  assign out_vld = s2_vld_q;
  assign out_dat = s2_dat_q;
  assign out_tag = s2_tag_q;
  assign err     = err_q;

endmodule

// File: tb/tb_stl_rot_unshift.sv
// Directed bench: three instances (MODE=0 16 lanes, MODE=1 16 lanes, MODE=0 12 lanes) sharing clock and reset.
module tb_stl_rot_unshift;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_err, a_err_clr;
  logic [159:0] a_in_dat, a_out_dat;
  logic [3:0]   a_in_shft, a_in_tag, a_out_tag;
  logic         b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_err, b_err_clr;
  logic [159:0] b_in_dat, b_out_dat;
  logic [3:0]   b_in_shft, b_in_tag, b_out_tag;
  logic         c_in_vld, c_in_rdy, c_out_vld, c_out_rdy, c_err, c_err_clr;
  logic [119:0] c_in_dat, c_out_dat;
  logic [3:0]   c_in_shft, c_in_tag, c_out_tag;

  stl_rot_unshift #(.DIM_N(16), .DAT_W(10), .SHT_W(4), .TAG_W(4), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_dat(a_in_dat),
    .in_shft(a_in_shft), .in_tag(a_in_tag), .out_vld(a_out_vld), .out_rdy(a_out_rdy),
    .out_dat(a_out_dat), .out_tag(a_out_tag), .err(a_err), .err_clr(a_err_clr));

  stl_rot_unshift #(.DIM_N(16), .DAT_W(10), .SHT_W(4), .TAG_W(4), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_dat(b_in_dat),
    .in_shft(b_in_shft), .in_tag(b_in_tag), .out_vld(b_out_vld), .out_rdy(b_out_rdy),
    .out_dat(b_out_dat), .out_tag(b_out_tag), .err(b_err), .err_clr(b_err_clr));

  stl_rot_unshift #(.DIM_N(12), .DAT_W(10), .SHT_W(4), .TAG_W(4), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .in_vld(c_in_vld), .in_rdy(c_in_rdy), .in_dat(c_in_dat),
    .in_shft(c_in_shft), .in_tag(c_in_tag), .out_vld(c_out_vld), .out_rdy(c_out_rdy),
    .out_dat(c_out_dat), .out_tag(c_out_tag), .err(c_err), .err_clr(c_err_clr));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 16-lane vector: lane j = base + ((j + off) mod 16)
  function automatic logic [159:0] lanes16(input int base, input int off);
    logic [159:0] v;
    for (int j = 0; j < 16; j++) v[j*10 +: 10] = 10'(base + ((j + off) % 16));
    return v;
  endfunction

  // 12-lane vector: lane j = 5*((j + off) mod 12) + 1
  function automatic logic [119:0] lanes12(input int off);
    logic [119:0] v;
    for (int j = 0; j < 12; j++) v[j*10 +: 10] = 10'(5 * ((j + off) % 12) + 1);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int idx;
    int seen;
    logic accept_now;

    {a_in_vld, a_out_rdy, a_err_clr, a_in_dat, a_in_shft, a_in_tag} = '0;
    {b_in_vld, b_out_rdy, b_err_clr, b_in_dat, b_in_shft, b_in_tag} = '0;
    {c_in_vld, c_out_rdy, c_err_clr, c_in_dat, c_in_shft, c_in_tag} = '0;

    // Reset values
    @(negedge clk);
    chk("rst_out_vld", 160'(a_out_vld), 160'(0));
    chk("rst_out_dat", a_out_dat, 160'(0));
    chk("rst_out_tag", 160'(a_out_tag), 160'(0));
    chk("rst_err", 160'(a_err), 160'(0));
    chk("rst_in_rdy", 160'(a_in_rdy), 160'(1));
    step();
    rst = 1'b0;
    a_out_rdy = 1'b1; b_out_rdy = 1'b1; c_out_rdy = 1'b1;
    step();

    // Identity, MODE=0, shift 3: lane j holds (j-3) mod 16
    a_in_vld = 1'b1; a_in_dat = lanes16(0, 13); a_in_shft = 4'd3; a_in_tag = 4'd5;
    step();
    a_in_vld = 1'b0;
    @(negedge clk);
    chk("id0_lat1_vld", 160'(a_out_vld), 160'(0));
    step();
    @(negedge clk);
    chk("id0_vld", 160'(a_out_vld), 160'(1));
    chk("id0_dat", a_out_dat, lanes16(0, 0));
    chk("id0_tag", 160'(a_out_tag), 160'(5));
    chk("id0_err", 160'(a_err), 160'(0));

    // MODE=1, shift 15: lane j holds (j+15) mod 16
    step();
    b_in_vld = 1'b1; b_in_dat = lanes16(0, 15); b_in_shft = 4'd15; b_in_tag = 4'd9;
    step();
    b_in_vld = 1'b1; b_in_dat = lanes16(100, 7); b_in_shft = 4'd0; b_in_tag = 4'd2;
    step();
    b_in_vld = 1'b0;
    @(negedge clk);
    chk("m1_s15_dat", b_out_dat, lanes16(0, 0));
    chk("m1_s15_tag", 160'(b_out_tag), 160'(9));
    step();
    @(negedge clk);
    chk("m1_s0_dat", b_out_dat, lanes16(100, 7));
    chk("m1_s0_tag", 160'(b_out_tag), 160'(2));

    // Streaming: 20 back-to-back words, shift cycling, tag = index
    step();
    fork
      begin
        for (int w = 0; w < 20; w++) begin
          a_in_vld = 1'b1; a_in_shft = 4'(w % 16); a_in_tag = 4'(w);
          a_in_dat = lanes16(w * 16, (16 - (w % 16)) % 16);
          step();
        end
        a_in_vld = 1'b0;
      end
      begin
        for (int c = 0; c < 10 && !a_out_vld; c++) @(negedge clk);
        chk("strm_start", 160'(a_out_vld), 160'(1));
        for (int w = 0; w < 20; w++) begin
          chk("strm_vld", 160'(a_out_vld), 160'(1));
          chk("strm_dat", a_out_dat, lanes16(w * 16, 0));
          chk("strm_tag", 160'(a_out_tag), 160'(w % 16));
          @(negedge clk);
        end
        chk("strm_end", 160'(a_out_vld), 160'(0));
      end
    join
    step();

    // Backpressure: 3 words (tags 1..3, shifts 5/9/12) with out_rdy low
    a_out_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 6 && acc < 3; c++) begin
      a_in_vld = 1'b1; a_in_tag = 4'(acc + 1);
      a_in_shft = (acc == 0) ? 4'd5 : (acc == 1) ? 4'd9 : 4'd12;
      a_in_dat = lanes16((acc + 1) * 64, 16 - int'(a_in_shft));
      @(negedge clk);
      if (!a_in_rdy) break;
      @(posedge clk);
      #1;
      acc++;
    end
    chk("bp_accepted", 160'(acc), 160'(2));
    chk("bp_in_rdy", 160'(a_in_rdy), 160'(0));
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      chk("bp_hold_vld", 160'(a_out_vld), 160'(1));
      chk("bp_hold_dat", a_out_dat, lanes16(64, 0));
      chk("bp_hold_tag", 160'(a_out_tag), 160'(1));
      chk("bp_hold_rdy", 160'(a_in_rdy), 160'(0));
    end
    step();
    a_out_rdy = 1'b1;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      accept_now = a_in_vld && a_in_rdy;
      if (a_out_vld) begin
        chk("bp_rel_dat", a_out_dat, lanes16((idx + 1) * 64, 0));
        chk("bp_rel_tag", 160'(a_out_tag), 160'(idx + 1));
        idx++;
      end
      step();
      if (accept_now) a_in_vld = 1'b0;
    end
    chk("bp_count", 160'(idx), 160'(3));

    // Overrange amount on the 12-lane instance
    @(negedge clk);
    chk("ovr_err_pre", 160'(c_err), 160'(0));
    step();
    c_in_vld = 1'b1; c_in_dat = lanes12(0); c_in_shft = 4'd14; c_in_tag = 4'd3;
    step();
    c_in_vld = 1'b0;
    @(negedge clk);
    chk("ovr_err_set", 160'(c_err), 160'(1));
    step();
    @(negedge clk);
    chk("ovr14_vld", 160'(c_out_vld), 160'(1));
    chk("ovr14_dat", 160'(c_out_dat), 160'(lanes12(2)));
    chk("ovr14_tag", 160'(c_out_tag), 160'(3));
    step(); step(); step();
    @(negedge clk);
    chk("ovr_err_sticky", 160'(c_err), 160'(1));
    step();
    c_err_clr = 1'b1;
    step();
    c_err_clr = 1'b0;
    @(negedge clk);
    chk("ovr_err_clr", 160'(c_err), 160'(0));
    step();
    c_err_clr = 1'b1; c_in_vld = 1'b1; c_in_dat = lanes12(0); c_in_shft = 4'd13; c_in_tag = 4'd4;
    step();
    c_err_clr = 1'b0; c_in_vld = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", 160'(c_err), 160'(1));
    step();
    @(negedge clk);
    chk("ovr13_dat", 160'(c_out_dat), 160'(lanes12(1)));
    chk("ovr13_tag", 160'(c_out_tag), 160'(4));

    // Reset with both stages full
    step();
    a_out_rdy = 1'b0;
    a_in_vld = 1'b1; a_in_dat = lanes16(320, 0); a_in_shft = 4'd0; a_in_tag = 4'd7;
    step();
    a_in_dat = lanes16(352, 0); a_in_tag = 4'd8;
    step();
    a_in_vld = 1'b0;
    @(negedge clk);
    chk("mid_full_vld", 160'(a_out_vld), 160'(1));
    chk("mid_full_rdy", 160'(a_in_rdy), 160'(0));
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 160'(a_out_vld), 160'(0));
    chk("mid_rst_dat", a_out_dat, 160'(0));
    chk("mid_rst_err", 160'(c_err), 160'(0));
    step();
    rst = 1'b0;
    a_out_rdy = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (a_out_vld) seen++;
      chk("post_rst_rdy", 160'(a_in_rdy), 160'(1));
      step();
    end
    chk("post_rst_stale", 160'(seen), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
